// File: rtl/pmp_pkg.sv
// Shared PMP types and constants for the sequential PMP checker.
// Optional scan skipping of OFF entries is enabled by PMP_SKIP_OFF_EN.
package pmp_pkg;

    localparam int PMP_ENTRIES = 16;

    typedef enum logic [1:0] {
        A_OFF   = 2'd0,
        A_TOR   = 2'd1,
        A_NA4   = 2'd2,
        A_NAPOT = 2'd3
    } pmp_a_e;

    typedef enum logic [1:0] {
        PRIV_U = 2'b00,
        PRIV_S = 2'b01,
        PRIV_M = 2'b11
    } priv_e;

    typedef enum logic [1:0] {
        ACC_LOAD  = 2'd0,
        ACC_STORE = 2'd1,
        ACC_FETCH = 2'd2
    } acc_e;

    typedef struct packed {
        logic       l;
        logic [1:0] rsvd;
        pmp_a_e     a;
        logic       x;
        logic       w;
        logic       r;
    } pmpcfg_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_RESP = 2'd2
    } state_e;

endpackage

// File: rtl/pmp_entry_match.sv
// Single-entry PMP region matcher: full and partial overlap of an access
// against one OFF/TOR/NA4/NAPOT region, using 34-bit physical addresses.
module pmp_entry_match
    import pmp_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] addr,
    input  logic [1:0]      size,
    input  pmpcfg_t         cfg,
    input  logic [XLEN-1:0] pmpaddr,
    input  logic [XLEN-1:0] prev_pmpaddr,
    input  logic            is_entry0,
    output logic            full_match,
    output logic            partial_match
);

    // Two spare bits so a full-space NAPOT top (2^35) stays representable.
    localparam int W = XLEN + 4;

    logic [W-1:0]  a_lo;
    logic [W-1:0]  a_hi;
    logic [W-1:0]  r_lo;
    logic [W-1:0]  r_hi;
    logic [W-1:0]  nbytes;
    logic [XLEN:0] mask;
    logic          en;
    logic          overlap;

    always_comb begin
        unique case (size)
            2'd0:    nbytes = W'(1);
            2'd1:    nbytes = W'(2);
            default: nbytes = W'(4);
        endcase
        a_lo = W'(addr);
        a_hi = a_lo + nbytes - W'(1);
        // Ones through the first zero: low t+1 bits for t trailing ones.
        mask = {1'b0, pmpaddr} ^ ({1'b0, pmpaddr} + {{XLEN{1'b0}}, 1'b1});
        r_lo = '0;
        r_hi = '0;
        en   = 1'b0;
        unique case (cfg.a)
            A_TOR: begin
                r_lo = is_entry0 ? '0 : (W'(prev_pmpaddr) << 2);
                r_hi = W'(pmpaddr) << 2;
                en   = r_lo < r_hi;
            end
            A_NA4: begin
                r_lo = W'(pmpaddr) << 2;
                r_hi = r_lo + W'(4);
                en   = 1'b1;
            end
            A_NAPOT: begin
                r_lo = W'(pmpaddr & ~mask[XLEN-1:0]) << 2;
                r_hi = r_lo + ((W'(mask) + W'(1)) << 2);
                en   = 1'b1;
            end
            default: en = 1'b0;
        endcase
        full_match    = en && (a_lo >= r_lo) && (a_hi < r_hi);
        overlap       = en && (a_lo < r_hi) && (a_hi >= r_lo);
        partial_match = overlap && !full_match;
    end

    logic unused_cfg;
    assign unused_cfg = ^{cfg.l, cfg.rsvd, cfg.x, cfg.w, cfg.r};

endmodule

// File: rtl/pmp_scan_ctrl.sv
// Sequential PMP checker: one shared matcher scans entries in priority order.
// Define PMP_SKIP_OFF_EN to jump over OFF entries during the scan.
module pmp_scan_ctrl
    import pmp_pkg::*;
#(
    parameter int NUM_ENTRIES = PMP_ENTRIES,
    parameter int XLEN        = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic [XLEN-1:0]           req_addr,
    input  logic [1:0]                req_size,
    input  logic [1:0]                req_acc,
    input  logic [1:0]                req_priv,
    input  logic [NUM_ENTRIES*XLEN-1:0] pmpaddr,
    input  logic [NUM_ENTRIES*8-1:0]  pmpcfg,
    input  logic                      cfg_wr,
    output logic                      resp_valid,
    input  logic                      resp_ready,
    output logic                      resp_allow,
    output logic                      resp_hit,
    output logic [3:0]                resp_entry
);

    state_e          state_q, state_d;
    logic [3:0]      idx_q, idx_d;
    logic [XLEN-1:0] addr_q, addr_d;
    logic [1:0]      size_q, size_d;
    logic [1:0]      acc_q, acc_d;
    logic [1:0]      priv_q, priv_d;
    logic            allow_q, allow_d;
    logic            hit_q, hit_d;
    logic [3:0]      entry_q, entry_d;

    logic [XLEN-1:0] addr_a [NUM_ENTRIES];
    pmpcfg_t         cfg_a  [NUM_ENTRIES];

    for (genvar g = 0; g < NUM_ENTRIES; g++) begin : g_unpack
        assign addr_a[g] = pmpaddr[g*XLEN +: XLEN];
        assign cfg_a[g]  = pmpcfg_t'(pmpcfg[g*8 +: 8]);
    end

    logic [3:0]      cur_idx;
    logic            cur_valid;
    logic            last;
    pmpcfg_t         cfg_sel;
    logic [XLEN-1:0] addr_sel;
    logic [XLEN-1:0] prev_sel;
    logic            full;
    logic            partial;
    logic            perm_ok;

`ifdef PMP_SKIP_OFF_EN
    logic more;

    always_comb begin
        cur_valid = 1'b0;
        cur_idx   = idx_q;
        more      = 1'b0;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            if (!cur_valid && i >= int'(idx_q) && cfg_a[i].a != A_OFF) begin
                cur_valid = 1'b1;
                cur_idx   = 4'(i);
            end else if (cur_valid && cfg_a[i].a != A_OFF) begin
                more = 1'b1;
            end
        end
        last = !more;
    end
`else
    assign cur_valid = 1'b1;
    assign cur_idx   = idx_q;
    assign last      = idx_q == 4'(NUM_ENTRIES - 1);
`endif

    assign cfg_sel  = cfg_a[cur_idx];
    assign addr_sel = addr_a[cur_idx];
    assign prev_sel = (cur_idx == 4'd0) ? '0 : addr_a[cur_idx - 4'd1];

    pmp_entry_match #(
        .XLEN(XLEN)
    ) u_match (
        .addr         (addr_q),
        .size         (size_q),
        .cfg          (cfg_sel),
        .pmpaddr      (addr_sel),
        .prev_pmpaddr (prev_sel),
        .is_entry0    (cur_idx == 4'd0),
        .full_match   (full),
        .partial_match(partial)
    );

    always_comb begin
        if (acc_q == 2'd3) begin
            perm_ok = 1'b0;
        end else if (priv_q == PRIV_M && !cfg_sel.l) begin
            perm_ok = 1'b1;
        end else if (acc_q == ACC_LOAD) begin
            perm_ok = cfg_sel.r;
        end else if (acc_q == ACC_STORE) begin
            perm_ok = cfg_sel.w;
        end else begin
            perm_ok = cfg_sel.x;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        addr_d  = addr_q;
        size_d  = size_q;
        acc_d   = acc_q;
        priv_d  = priv_q;
        allow_d = allow_q;
        hit_d   = hit_q;
        entry_d = entry_q;
        unique case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    addr_d  = req_addr;
                    size_d  = req_size;
                    acc_d   = req_acc;
                    priv_d  = req_priv;
                    idx_d   = '0;
                    state_d = ST_SCAN;
                end
            end
            ST_SCAN: begin
                if (cfg_wr) begin
                    idx_d = '0;
                end else if (cur_valid && (full || partial)) begin
                    hit_d   = 1'b1;
                    entry_d = cur_idx;
                    allow_d = full && perm_ok;
                    state_d = ST_RESP;
                end else if (last) begin
                    hit_d   = 1'b0;
                    entry_d = '0;
                    allow_d = (priv_q == PRIV_M) && (acc_q != 2'd3);
                    state_d = ST_RESP;
                end else begin
                    idx_d = cur_idx + 4'd1;
                end
            end
            ST_RESP: begin
                if (resp_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            addr_q  <= '0;
            size_q  <= '0;
            acc_q   <= '0;
            priv_q  <= '0;
            allow_q <= 1'b0;
            hit_q   <= 1'b0;
            entry_q <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            addr_q  <= addr_d;
            size_q  <= size_d;
            acc_q   <= acc_d;
            priv_q  <= priv_d;
            allow_q <= allow_d;
            hit_q   <= hit_d;
            entry_q <= entry_d;
        end
    end

    assign req_ready  = state_q == ST_IDLE;
    assign resp_valid = state_q == ST_RESP;
    assign resp_allow = allow_q;
    assign resp_hit   = hit_q;
    assign resp_entry = entry_q;

    logic unused_rsvd;
    assign unused_rsvd = ^cfg_sel.rsvd;

endmodule

// File: tb/tb_pmp_scan_ctrl.sv
// Scoreboard bench for pmp_scan_ctrl: directed requests push expectations,
// a negedge monitor compares every presented response.
module tb_pmp_scan_ctrl;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         req_valid = 1'b0;
    logic         req_ready;
    logic [31:0]  req_addr = '0;
    logic [1:0]   req_size = '0;
    logic [1:0]   req_acc = '0;
    logic [1:0]   req_priv = '0;
    logic [511:0] pmpaddr;
    logic [127:0] pmpcfg;
    logic         cfg_wr = 1'b0;
    logic         resp_valid;
    logic         resp_ready = 1'b1;
    logic         resp_allow;
    logic         resp_hit;
    logic [3:0]   resp_entry;

    logic [31:0]  pa [16];
    logic [7:0]   pc [16];

    always_comb begin
        pmpaddr = '0;
        pmpcfg  = '0;
        for (int i = 0; i < 16; i++) begin
            pmpaddr[i*32 +: 32] = pa[i];
            pmpcfg[i*8 +: 8]    = pc[i];
        end
    end

    pmp_scan_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .req_size  (req_size),
        .req_acc   (req_acc),
        .req_priv  (req_priv),
        .pmpaddr   (pmpaddr),
        .pmpcfg    (pmpcfg),
        .cfg_wr    (cfg_wr),
        .resp_valid(resp_valid),
        .resp_ready(resp_ready),
        .resp_allow(resp_allow),
        .resp_hit  (resp_hit),
        .resp_entry(resp_entry)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic       hit;
        logic [3:0] entry;
        logic       allow;
        int         lat;
        int         t0;
        bit         seen;
        string      name;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   failures = 0;

    always @(negedge clk) begin
        if (!rst && resp_valid) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_resp: got valid hit=%0b entry=%0d, required no response",
                         resp_hit, resp_entry);
            end else begin
                exp_t e;
                e = sb[0];
                checks++;
                if ({resp_hit, resp_entry, resp_allow} !== {e.hit, e.entry, e.allow}) begin
                    failures++;
                    $display("FAIL %s: hit=%0b entry=%0d allow=%0b, required hit=%0b entry=%0d allow=%0b",
                             e.name, resp_hit, resp_entry, resp_allow, e.hit, e.entry, e.allow);
                end
                checks++;
                if (req_ready !== 1'b0) begin
                    failures++;
                    $display("FAIL %s_req_ready: got %0b, required 0", e.name, req_ready);
                end
                if (!e.seen) begin
                    checks++;
                    if (cyc - e.t0 != e.lat) begin
                        failures++;
                        $display("FAIL %s_latency: got %0d, required %0d", e.name, cyc - e.t0, e.lat);
                    end
                    sb[0].seen = 1'b1;
                end
                if (resp_ready) void'(sb.pop_front());
            end
        end
    end

    function automatic logic [7:0] cfgb(input logic l, input logic [1:0] a,
                                        input logic x, input logic w, input logic r);
        return {l, 2'b00, a, x, w, r};
    endfunction

    task automatic clear_cfg();
        for (int i = 0; i < 16; i++) begin
            pa[i] = '0;
            pc[i] = '0;
        end
    endtask

    task automatic issue(input logic [31:0] a, input logic [1:0] sz, input logic [1:0] ac,
                         input logic [1:0] pv, output int t);
        req_addr  = a;
        req_size  = sz;
        req_acc   = ac;
        req_priv  = pv;
        req_valid = 1'b1;
        t = cyc + 1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic drain(input string nm);
        int n;
        n = 0;
        while (sb.size() != 0 && n < 80) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (sb.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL %s_timeout: pending=%0d, required 0", nm, sb.size());
            sb.delete();
        end
    endtask

    task automatic do_req(input logic [31:0] a, input logic [1:0] sz, input logic [1:0] ac,
                          input logic [1:0] pv, input logic eh, input logic [3:0] ee,
                          input logic ea, input int lat, input string nm);
        exp_t e;
        int   t;
        issue(a, sz, ac, pv, t);
        e.hit = eh; e.entry = ee; e.allow = ea;
        e.lat = lat; e.t0 = t; e.seen = 1'b0; e.name = nm;
        sb.push_back(e);
        drain(nm);
    endtask

    initial begin
        exp_t e;
        int   t;
        int   n;
        clear_cfg();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({req_ready, resp_valid, resp_hit, resp_allow, resp_entry} !== 8'b1000_0000) begin
            failures++;
            $display("FAIL reset_state: rdy=%0b vld=%0b hit=%0b allow=%0b entry=%0d, required 1 0 0 0 0",
                     req_ready, resp_valid, resp_hit, resp_allow, resp_entry);
        end
        rst = 1'b0;
        @(posedge clk);
        #1;

        do_req(32'h1000, 2'd2, 2'd0, 2'b00, 1'b0, 4'd0, 1'b0, 16, "nocfg_u");
        do_req(32'h1000, 2'd2, 2'd0, 2'b11, 1'b0, 4'd0, 1'b1, 16, "nocfg_m");
        do_req(32'h1000, 2'd2, 2'd3, 2'b11, 1'b0, 4'd0, 1'b0, 16, "nocfg_m_acc3");

        // 0x5FF -> NAPOT base 0x1000, 4 KiB
        pa[3] = 32'h0000_05FF;
        pc[3] = cfgb(1'b0, 2'd3, 1'b0, 1'b0, 1'b1);
        do_req(32'h1800, 2'd2, 2'd1, 2'b00, 1'b1, 4'd3, 1'b0, 4, "napot_store");
        do_req(32'h1800, 2'd2, 2'd0, 2'b00, 1'b1, 4'd3, 1'b1, 4, "napot_load");
        do_req(32'h2000, 2'd0, 2'd0, 2'b00, 1'b0, 4'd0, 1'b0, 16, "napot_above");

        clear_cfg();
        pa[0] = 32'h0000_0400;
        pc[0] = cfgb(1'b0, 2'd1, 1'b0, 1'b0, 1'b1);
        pa[1] = 32'h0;
        pc[1] = cfgb(1'b0, 2'd2, 1'b0, 1'b0, 1'b1);
        do_req(32'h0FFE, 2'd2, 2'd0, 2'b01, 1'b1, 4'd0, 1'b0, 1, "tor_partial");
        do_req(32'h0FFC, 2'd2, 2'd0, 2'b01, 1'b1, 4'd0, 1'b1, 1, "tor_full");
        do_req(32'h1000, 2'd0, 2'd0, 2'b01, 1'b0, 4'd0, 1'b0, 16, "tor_top_excl");

        clear_cfg();
        pa[5] = 32'h0000_0400;
        pc[5] = cfgb(1'b0, 2'd2, 1'b0, 1'b0, 1'b1);
        do_req(32'h1000, 2'd3, 2'd0, 2'b00, 1'b1, 4'd5, 1'b1, 6, "na4_size3_full");
        do_req(32'h1002, 2'd3, 2'd0, 2'b00, 1'b1, 4'd5, 1'b0, 6, "na4_size3_part");
        do_req(32'h1003, 2'd0, 2'd0, 2'b00, 1'b1, 4'd5, 1'b1, 6, "na4_last_byte");

        clear_cfg();
        pa[0] = 32'h0000_0200;
        pa[1] = 32'h0000_0100;
        pc[1] = cfgb(1'b0, 2'd1, 1'b1, 1'b1, 1'b1);
        do_req(32'h0500, 2'd0, 2'd0, 2'b00, 1'b0, 4'd0, 1'b0, 16, "tor_empty");

        clear_cfg();
        pa[2] = 32'h0000_05FF;
        pc[2] = cfgb(1'b1, 2'd3, 1'b0, 1'b0, 1'b1);
        do_req(32'h1004, 2'd2, 2'd2, 2'b11, 1'b1, 4'd2, 1'b0, 3, "lock_fetch_m");
        do_req(32'h1004, 2'd2, 2'd0, 2'b11, 1'b1, 4'd2, 1'b1, 3, "lock_load_m");
        pc[2] = cfgb(1'b0, 2'd3, 1'b0, 1'b0, 1'b1);
        do_req(32'h1004, 2'd2, 2'd2, 2'b11, 1'b1, 4'd2, 1'b1, 3, "unlock_fetch_m");
        do_req(32'h1004, 2'd2, 2'd3, 2'b11, 1'b1, 4'd2, 1'b0, 3, "acc3_m");
        do_req(32'h1004, 2'd2, 2'd2, 2'b00, 1'b1, 4'd2, 1'b0, 3, "fetch_u");

        clear_cfg();
        pa[10] = 32'h0000_05FF;
        pc[10] = cfgb(1'b0, 2'd3, 1'b0, 1'b0, 1'b1);
        resp_ready = 1'b0;
        issue(32'h1000, 2'd2, 2'd0, 2'b00, t);
        e.hit = 1'b1; e.entry = 4'd10; e.allow = 1'b1;
        e.lat = 11; e.t0 = t; e.seen = 1'b0; e.name = "cfgwr_restart";
        sb.push_back(e);
        repeat (4) @(posedge clk);
        #1;
        cfg_wr = 1'b1;
        sb[0].t0 = cyc + 1;
        @(posedge clk);
        #1;
        cfg_wr = 1'b0;
        n = 0;
        while (!resp_valid && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        repeat (3) @(posedge clk);
        #1;
        resp_ready = 1'b1;
        drain("cfgwr_restart");

        issue(32'h1000, 2'd2, 2'd0, 2'b00, t);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
            failures++;
            $display("FAIL mid_scan_reset: rdy=%0b vld=%0b, required 1 0", req_ready, resp_valid);
        end
        rst = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        checks++;
        if (req_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_idle: rdy=%0b, required 1", req_ready);
        end
        do_req(32'h1000, 2'd2, 2'd1, 2'b00, 1'b1, 4'd10, 1'b0, 11, "after_reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
